// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the write-back scheduler: instruction codes,
// special register ids, the queued write entry and the scheduler FSM states.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wb_ent_t;

    localparam wb_ent_t WB_NONE = '{addr: RNONE, data: 64'd0};

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } wb_state_e;

endpackage

// File: rtl/wb_write_sched_if.sv
// W-stage / register-file port bundle of the write-back scheduler.
//   master: W-stage side (drives W_*, rd_addr; sees stall, write port, lookup)
//   slave : the scheduler itself
interface wb_write_sched_if;
    logic        W_valid;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic        W_stall;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        bad_icode;
    logic [3:0]  rd_addr;
    logic        rd_hit;
    logic [63:0] rd_data;

    modport master (
        output W_valid, W_icode, W_dstE, W_dstM, W_valE, W_valM, rd_addr,
        input  W_stall, wr_en, wr_addr, wr_data, bad_icode, rd_hit, rd_data
    );

    modport slave (
        input  W_valid, W_icode, W_dstE, W_dstM, W_valE, W_valM, rd_addr,
        output W_stall, wr_en, wr_addr, wr_data, bad_icode, rd_hit, rd_data
    );
endinterface

// File: rtl/wb_write_sched_fifo.sv
// wb_fifo: DEPTH-entry write queue, 2-wide push / 1-wide pop.
// Ports: clk, rst_n; push0/din0 (older), push1/din1 (younger, only with push0);
// pop; count (0..DEPTH); ent/ent_vld = entries in age order, ent[0] = head.
module wb_fifo
    import y86_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push0,
    input  logic                  push1,
    input  wb_ent_t               din0,
    input  wb_ent_t               din1,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output wb_ent_t [DEPTH-1:0]   ent,
    output logic [DEPTH-1:0]      ent_vld
);
    wb_ent_t       mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= din0;
        if (push1) mem[wr_ptr + AW'(1)] <= din1;
    end

    // DEPTH is a power of two, so pointers wrap by truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent[i]     = mem[rd_ptr + AW'(i)];
            ent_vld[i] = (CW'(i) < count);
        end
    end
endmodule

// File: rtl/wb_write_sched.sv
// wb_write_sched: decodes each retiring instruction into 0..2 register writes,
// queues them and drains one per cycle onto the single register-file port.
// Ports: clk, rst_n (async, active low); bus (wb_write_sched_if.slave):
//   W_* in / W_stall out, wr_en/wr_addr/wr_data out, bad_icode out,
//   rd_addr in / rd_hit, rd_data out (pending-write lookup).
// Build option: WB_SCHED_BYPASS_EN enables the lookup; otherwise rd_hit and
// rd_data are tied to zero.
module wb_write_sched
    import y86_pkg::*;
#(
    parameter int DEPTH = 4,  // power of two, >= 2
    localparam int CW = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst_n,
    wb_write_sched_if.slave bus
);
    wb_state_e           state_q, state_d;
    logic                out_en_q, out_en_d;
    wb_ent_t             out_q, out_d;
    logic                bad_q;
    logic [CW-1:0]       count;
    wb_ent_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0]    ent_vld;
    logic                stall, acc, pop, push0, push1;
    logic                e_use, m_use, has0, has1;
    wb_ent_t             e_wr, m_wr, w0, din0;

    // Registered state only: no combinational path from W_* to the stall.
    assign stall = (count > CW'(DEPTH - 2));
    assign acc   = bus.W_valid & ~stall;

    always_comb begin
        e_wr  = '{addr: bus.W_dstE, data: bus.W_valE};
        m_wr  = '{addr: bus.W_dstM, data: bus.W_valM};
        e_use = 1'b0;
        m_use = 1'b0;
        case (bus.W_icode)
            IRRMOVQ, IIRMOVQ, IOPQ: e_use = 1'b1;
            IMRMOVQ:                m_use = 1'b1;
            ICALL, IRET, IPUSHQ: begin
                e_use     = 1'b1;
                e_wr.addr = RRSP;
            end
            // E (%rsp) is listed first, so a popq %rsp leaves the loaded value.
            IPOPQ: begin
                e_use     = 1'b1;
                m_use     = 1'b1;
                e_wr.addr = RRSP;
            end
            IHALT, INOP, IRMMOVQ, IJXX: ;
            default: ;
        endcase
        e_use = e_use & (e_wr.addr != RNONE);
        m_use = m_use & (m_wr.addr != RNONE);
    end

    // Compact the surviving writes: w0 is the older one, m_wr the younger.
    assign w0   = e_use ? e_wr : m_wr;
    assign has0 = acc & (e_use | m_use);
    assign has1 = acc & e_use & m_use;

    // Queued writes are older than anything arriving now, so the head goes
    // out first; with an empty queue the first new write bypasses it.
    always_comb begin
        pop      = (state_q == S_DRAIN) & ent_vld[0];
        out_en_d = 1'b0;
        out_d    = WB_NONE;
        push0    = 1'b0;
        push1    = 1'b0;
        din0     = w0;
        if (pop) begin
            out_en_d = 1'b1;
            out_d    = ent[0];
            push0    = has0;
            push1    = has1;
        end else begin
            out_en_d = has0;
            if (has0) out_d = w0;
            push0 = has1;
            din0  = m_wr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (has0)      state_d = S_DRAIN;
            S_DRAIN: if (!out_en_d) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            out_en_q <= 1'b0;
            out_q    <= WB_NONE;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_en_q <= out_en_d;
            out_q    <= out_d;
            bad_q    <= acc & (bus.W_icode >= 4'hC);
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push0   (push0),
        .push1   (push1),
        .din0    (din0),
        .din1    (m_wr),
        .pop     (pop),
        .count   (count),
        .ent     (ent),
        .ent_vld (ent_vld)
    );

    assign bus.W_stall   = stall;
    assign bus.wr_en     = out_en_q;
    assign bus.wr_addr   = out_q.addr;
    assign bus.wr_data   = out_q.data;
    assign bus.bad_icode = bad_q;

`ifdef WB_SCHED_BYPASS_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.rd_hit  = 1'b0;
        bus.rd_data = 64'd0;
        if (out_en_q && out_q.addr == bus.rd_addr) begin
            bus.rd_hit  = 1'b1;
            bus.rd_data = out_q.data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent[i].addr == bus.rd_addr) begin
                bus.rd_hit  = 1'b1;
                bus.rd_data = ent[i].data;
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{ent, ent_vld, bus.rd_addr};
    assign bus.rd_hit    = 1'b0;
    assign bus.rd_data   = 64'd0;
`endif
endmodule

// File: tb/tb_wb_write_sched.sv
module tb_wb_write_sched;
    import y86_pkg::*;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_sched_if bus();
    wb_write_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of writes not yet presented plus the one on the port.
    typedef struct { logic [3:0] a; logic [63:0] d; } wr_t;
    wr_t mq[$];
    bit  m_en  = 1'b0;
    wr_t m_cur = '{4'hF, 64'd0};
    bit  m_bad = 1'b0;

    function automatic void add_wr(input logic [3:0] a, input logic [63:0] d);
        if (a != 4'hF) mq.push_back('{a, d});
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_en  = 1'b0;
            m_cur = '{4'hF, 64'd0};
            m_bad = 1'b0;
        end else begin
            bit acc;
            acc   = bus.W_valid && (mq.size() <= DEPTH - 2);
            m_bad = acc && (bus.W_icode >= 4'hC);
            if (acc) begin
                case (bus.W_icode)
                    4'h2, 4'h3, 4'h6:  add_wr(bus.W_dstE, bus.W_valE);
                    4'h5:              add_wr(bus.W_dstM, bus.W_valM);
                    4'h8, 4'h9, 4'hA:  add_wr(4'h4, bus.W_valE);
                    4'hB: begin
                        add_wr(4'h4, bus.W_valE);
                        add_wr(bus.W_dstM, bus.W_valM);
                    end
                    default: ;
                endcase
            end
            m_en = (mq.size() > 0);
            if (m_en) m_cur = mq.pop_front();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        bit          eh;
        logic [63:0] ed;
        @(negedge clk);
        #2;
        chk("wr_en", 64'(bus.wr_en), 64'(m_en));
        if (m_en) begin
            chk("wr_addr", 64'(bus.wr_addr), 64'(m_cur.a));
            chk("wr_data", bus.wr_data, m_cur.d);
        end
        chk("W_stall", 64'(bus.W_stall), 64'(mq.size() > DEPTH - 2));
        chk("bad_icode", 64'(bus.bad_icode), 64'(m_bad));
        eh = 1'b0;
        ed = 64'd0;
`ifdef WB_SCHED_BYPASS_EN
        if (m_en && m_cur.a == bus.rd_addr) begin eh = 1'b1; ed = m_cur.d; end
        foreach (mq[i]) if (mq[i].a == bus.rd_addr) begin eh = 1'b1; ed = mq[i].d; end
`endif
        chk("rd_hit", 64'(bus.rd_hit), 64'(eh));
        chk("rd_data", bus.rd_data, ed);
    end

    // Write log and register-file image built from what the DUT emits.
    wr_t         wlog[$];
    logic [63:0] dut_rf [16];
    initial forever begin
        @(negedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            wlog.push_back('{bus.wr_addr, bus.wr_data});
            dut_rf[bus.wr_addr] = bus.wr_data;
        end
    end

    task automatic drive(input bit v, input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        bus.W_valid = v;
        bus.W_icode = ic;
        bus.W_dstE  = de;
        bus.W_dstM  = dm;
        bus.W_valE  = ve;
        bus.W_valM  = vm;
    endtask

    task automatic idle();
        drive(1'b0, INOP, 4'hF, 4'hF, 64'd0, 64'd0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((m_en || mq.size() > 0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("drain_bound", 64'(k < 20), 64'd1);
    endtask

    function automatic logic [3:0] rnd_dst();
        return ($urandom_range(0, 99) < 20) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    initial begin
        int base;
        int t;
        idle();
        bus.rd_addr = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst wr_addr", 64'(bus.wr_addr), 64'hF);
        chk("rst wr_data", bus.wr_data, 64'd0);
        chk("rst W_stall", 64'(bus.W_stall), 64'd0);
        chk("rst bad_icode", 64'(bus.bad_icode), 64'd0);
        chk("rst rd_hit", 64'(bus.rd_hit), 64'd0);
        chk("rst rd_data", bus.rd_data, 64'd0);

        // irmovq -> r3 = 0x55, one cycle on the port
        @(negedge clk); drive(1'b1, IIRMOVQ, 4'h3, 4'hF, 64'h55, 64'd0);
        @(negedge clk); idle(); #2;
        chk("irmovq wr_en", 64'(bus.wr_en), 64'd1);
        chk("irmovq wr_addr", 64'(bus.wr_addr), 64'd3);
        chk("irmovq wr_data", bus.wr_data, 64'h55);
        @(negedge clk); #2;
        chk("irmovq done", 64'(bus.wr_en), 64'd0);

        // popq %rsp: rsp update first, loaded value last
        @(negedge clk); drive(1'b1, IPOPQ, 4'hF, 4'h4, 64'h108, 64'h77);
        @(negedge clk); idle(); #2;
        chk("popq w1 addr", 64'(bus.wr_addr), 64'd4);
        chk("popq w1 data", bus.wr_data, 64'h108);
        @(negedge clk); #2;
        chk("popq w2 en", 64'(bus.wr_en), 64'd1);
        chk("popq w2 addr", 64'(bus.wr_addr), 64'd4);
        chk("popq w2 data", bus.wr_data, 64'h77);
        @(negedge clk); #2;
        chk("popq rsp final", dut_rf[4], 64'h77);

        // four back-to-back popq: fourth one is held off by the stall
        wait_drain();
        base = wlog.size();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, IPOPQ, 4'hF, 4'(k + 1), 64'h1000 + 64'(k), 64'h2000 + 64'(k));
            #2;
            chk("popq burst stall", 64'(bus.W_stall), 64'(k == 3));
            t = 0;
            while (bus.W_stall && t < 10) begin
                @(negedge clk); #2; t++;
            end
            chk("popq burst accept bound", 64'(t < 10), 64'd1);
            @(negedge clk);
        end
        idle();
        wait_drain();
        chk("popq burst count", 64'(wlog.size() - base), 64'd8);
        if (wlog.size() >= base + 8) begin
            for (int k = 0; k < 4; k++) begin
                chk("burst E addr", 64'(wlog[base + 2*k].a), 64'd4);
                chk("burst E data", wlog[base + 2*k].d, 64'h1000 + 64'(k));
                chk("burst M addr", 64'(wlog[base + 2*k + 1].a), 64'(k + 1));
                chk("burst M data", wlog[base + 2*k + 1].d, 64'h2000 + 64'(k));
            end
        end

        // OPq to RNONE writes nothing; illegal icode pulses bad_icode
        @(negedge clk); drive(1'b1, IOPQ, 4'hF, 4'hF, 64'h99, 64'd0);
        @(negedge clk); drive(1'b1, 4'hE, 4'h1, 4'h2, 64'h5, 64'h6); #2;
        chk("opq none wr_en", 64'(bus.wr_en), 64'd0);
        chk("bad before", 64'(bus.bad_icode), 64'd0);
        @(negedge clk); idle(); #2;
        chk("bad pulse", 64'(bus.bad_icode), 64'd1);
        chk("bad no write", 64'(bus.wr_en), 64'd0);
        @(negedge clk); #2;
        chk("bad cleared", 64'(bus.bad_icode), 64'd0);

        // reset with three writes pending
        @(negedge clk); drive(1'b1, IPOPQ, 4'hF, 4'h5, 64'hA1, 64'hA2);
        @(negedge clk); drive(1'b1, IPOPQ, 4'hF, 4'h6, 64'hB1, 64'hB2);
        @(negedge clk); idle(); rst_n = 1'b0; #2;
        chk("mid reset wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid reset wr_addr", 64'(bus.wr_addr), 64'hF);
        base = wlog.size();
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #2;
            chk("post reset wr_en", 64'(bus.wr_en), 64'd0);
        end
        chk("post reset log", 64'(wlog.size()), 64'(base));

        // two pending writes to r2: youngest wins the lookup
        @(negedge clk); drive(1'b1, IPOPQ, 4'hF, 4'h5, 64'hC1, 64'hC2);
        @(negedge clk); drive(1'b1, IIRMOVQ, 4'h2, 4'hF, 64'h10, 64'd0);
        @(negedge clk); drive(1'b1, IIRMOVQ, 4'h2, 4'hF, 64'h20, 64'd0);
        @(negedge clk); idle(); bus.rd_addr = 4'h2; #2;
`ifdef WB_SCHED_BYPASS_EN
        chk("bypass hit", 64'(bus.rd_hit), 64'd1);
        chk("bypass data", bus.rd_data, 64'h20);
`else
        chk("no bypass hit", 64'(bus.rd_hit), 64'd0);
        chk("no bypass data", bus.rd_data, 64'd0);
`endif
        @(negedge clk);
        wait_drain();

        // randomized traffic, model compared every cycle
        repeat (3000) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 99) < 75,
                  ($urandom_range(0, 99) < 30) ? IPOPQ : 4'($urandom_range(0, 15)),
                  rnd_dst(), rnd_dst(), {$urandom, $urandom}, {$urandom, $urandom});
            bus.rd_addr = 4'($urandom_range(0, 15));
        end
        @(negedge clk); rst_n = 1'b1; idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_write_sched.md
# wb_write_sched

Write-back scheduler between the W pipeline register and the single-write-port register file. It decodes each retiring instruction into zero, one or two register writes, queues them, and drains them onto one write port at one write per cycle. It applies backpressure to the W stage when the queue cannot absorb a worst-case instruction. It also orders the two `popq` writes so that the `%rsp` update lands before the memory load.

## Interface
- `DEPTH`, 4: write-queue entries; power of two, minimum 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `W_valid` input 1: W stage holds a retiring instruction.
- `W_icode` input 4: instruction code.
- `W_dstE` input 4: E destination register; 4'hF means none.
- `W_dstM` input 4: M destination register; 4'hF means none.
- `W_valE` input 64: ALU result.
- `W_valM` input 64: memory result.
- `W_stall` output 1: W stage must hold; the instruction is not accepted this cycle.
- `wr_en` output 1: register-file write strobe.
- `wr_addr` output 4: register-file write address.
- `wr_data` output 64: register-file write data.
- `bad_icode` output 1: one-cycle pulse after an accepted illegal icode.
- `rd_addr` input 4: decode-stage lookup address (bypass).
- `rd_hit` output 1: a pending write targets `rd_addr`.
- `rd_data` output 64: data of the youngest pending write to `rd_addr`.

## Operation
- Accept condition: `W_valid & ~W_stall`.
- Decode of an accepted instruction, with writes listed in order:
  - irmovq (3), cmovxx (2), OPq (6): E write to `W_dstE`.
  - mrmovq (5): M write to `W_dstM`.
  - pushq (A), call (8), ret (9): E write to register 4 (`%rsp`).
  - popq (B): E write to register 4, then M write to `W_dstM`.
  - halt (0), nop (1), rmmovq (4), jxx (7): no write.
  - Icode C–F: no write; `bad_icode` pulses in the next cycle.
- Any write whose address is 4'hF is dropped and never queued.
- `popq %rsp`: both writes are issued, M last, so the loaded value wins.
- Queue: FIFO of {addr, data}; `count` ranges 0..DEPTH.
- Output register: each cycle it takes the oldest pending write, or `wr_en`=0 if none is pending.
- If the queue is empty at acceptance, the first write goes straight to the output register and the second, if any, enters the queue.
- `count` update on simultaneous push and pop: `count_next = count + pushes − pop`, where pushes ∈ {0,1,2} and pop ∈ {0,1}.
- `W_stall = (count > DEPTH−2)`. It is computed from registered state only, so there is no combinational path from `W_*` inputs.
- States:
  - IDLE: `count`=0 and output register empty.
  - DRAIN: any write pending.
  - IDLE→DRAIN on an accept with ≥1 write.
  - DRAIN→IDLE when the last entry is popped and nothing is pushed.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=4'hF, `wr_data`=0, `W_stall`=0, `bad_icode`=0, `rd_hit`=0, `rd_data`=0, queue empty.
- Reset asserted mid-operation discards all pending writes immediately.
- Latency: for an instruction accepted at edge N, its first write has `wr_en`=1 in cycle N..N+1 and is committed by the register file at edge N+1. A popq's M write follows one cycle later.
- Throughput: a sustained stream of single-write instructions runs at 1/cycle with no stall.
- Each popq nets +1 entry. Once `count` > DEPTH−2, `W_stall` holds until the drain reduces `count`.
- `rd_hit`/`rd_data` are combinational over the output register and queue entries only. Writes being accepted this cycle are not visible.

## Configuration
- `WB_SCHED_BYPASS_EN` defined: the lookup is implemented. It searches the queue plus the output register, and the youngest match wins.
- `WB_SCHED_BYPASS_EN` undefined: the ports remain, `rd_hit`=0 and `rd_data`=0 constantly, and no comparators are built.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - `RNONE`=4'hF and `RRSP`=4'h4.
  - The write-entry struct {addr[3:0], data[63:0]}.
- One sub-module, `wb_fifo`:
  - DEPTH-entry queue with a 2-wide push and a 1-wide pop.
  - Exposes its entry array for the bypass search.
- The decode and output-register logic stay in the top level.

## Test plan
- Reset, then irmovq with `W_dstE`=3 and `W_valE`=0x55 → next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=0x55; the cycle after, `wr_en`=0.
- popq with `W_dstM`=4, `W_valE`=0x108, `W_valM`=0x77 → cycle 1 (4, 0x108), cycle 2 (4, 0x77); the final %rsp value is 0x77.
- Four back-to-back popq with DEPTH=4 → `W_stall` rises when `count`=3, all 8 writes emerge in order, and no write is lost or duplicated.
- OPq with `W_dstE`=F, then icode E → no `wr_en`; `bad_icode` pulses one cycle after the icode E is accepted.
- Reset pulsed while 3 writes are pending → `wr_en`=0 immediately and nothing is written after release.
- Bypass build: two queued writes to register 2 (0x10, then 0x20) with `rd_addr`=2 → `rd_hit`=1 and `rd_data`=0x20. Non-bypass build: `rd_hit`=0.
